// File: rtl/mono_rx_pkg.sv
// Shared types and default configuration for the MONOPIX readout sequencer.
// No logic; no latency; no backpressure.
package mono_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FREEZE,
        ST_READ,
        ST_SHIFT,
        ST_STORE,
        ST_GAP,
        ST_UNFREEZE
    } state_t;

    localparam int          PHASE_W        = 8;
    localparam logic [7:0]  DEF_FREEZE_DLY = 8'd2;
    localparam logic [3:0]  DEF_READ_WIDTH = 4'd2;
    localparam logic [5:0]  DEF_DATA_BITS  = 6'd26;
    localparam logic [7:0]  DEF_STOP_DLY   = 8'd4;

    // Phase counter reload for a length where 0 means 1: max(v,1)-1.
    function automatic logic [PHASE_W-1:0] len_to_cnt(input logic [PHASE_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/mono_rx_token_sync.sv
// 2-FF synchroniser for the asynchronous chip token plus rising-edge detect.
// Latency: sync_out 2 cycles after input, rise combinational on top of it.
// Backpressure: none.
module mono_rx_token_sync (
    input  logic RX_CLK,
    input  logic RX_RST_N,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic sync_d;

    always_ff @(posedge RX_CLK or negedge RX_RST_N) begin
        if (!RX_RST_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            sync_d <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~sync_d;

endmodule

// File: rtl/mono_rx_readout_ctrl.sv
// Token-driven readout sequencer: FREEZE/READ to the chip, SHIFT_EN/DATA_STROBE to the deserialiser.
// Latency: FREEZE 3+CONF_FREEZE_DLY cycles after token edge; hits every READ+BITS+2 cycles.
// Backpressure: FIFO_FULL holds the FSM in STORE with no strobe and no further READ.
module mono_rx_readout_ctrl
    import mono_rx_pkg::*;
#(
    parameter int TS_WIDTH        = 64,
    parameter int DATA_BITS_WIDTH = 6,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       RX_CLK,
    input  logic                       RX_RST_N,
    input  logic                       ENABLE,
    input  logic                       RX_TOKEN,
    input  logic [TS_WIDTH-1:0]        TIMESTAMP,
    input  logic [7:0]                 CONF_FREEZE_DLY,
    input  logic [3:0]                 CONF_READ_WIDTH,
    input  logic [DATA_BITS_WIDTH-1:0] CONF_DATA_BITS,
    input  logic [7:0]                 CONF_STOP_DLY,
    input  logic [CNT_WIDTH-1:0]       CONF_MAX_HITS,
    input  logic                       FIFO_FULL,
    output logic                       RX_FREEZE,
    output logic                       RX_READ,
    output logic                       SHIFT_EN,
    output logic                       DATA_STROBE,
    output logic [TS_WIDTH-1:0]        TOKEN_TIMESTAMP,
    output logic                       BUSY,
    output logic [CNT_WIDTH-1:0]       HIT_CNT,
    output logic                       OVERFLOW
);

    state_t               state, state_nxt;
    logic [PHASE_W-1:0]   cnt, cnt_nxt;
    logic                 tok_s, tok_rise;
    logic                 start, hit_inc, ovf_set;
    logic                 limit_hit;
    logic [PHASE_W-1:0]   read_cnt, bits_cnt;

    mono_rx_token_sync u_token_sync (
        .RX_CLK   (RX_CLK),
        .RX_RST_N (RX_RST_N),
        .async_in (RX_TOKEN),
        .sync_out (tok_s),
        .rise     (tok_rise)
    );

    assign read_cnt  = len_to_cnt(PHASE_W'(CONF_READ_WIDTH));
    assign bits_cnt  = len_to_cnt(PHASE_W'(CONF_DATA_BITS));
    assign limit_hit = (CONF_MAX_HITS != '0) && (HIT_CNT == CONF_MAX_HITS);

    always_ff @(posedge RX_CLK or negedge RX_RST_N) begin
        if (!RX_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One phase counter shared by every timed state; it is reloaded on each transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
        start     = 1'b0;
        hit_inc   = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tok_rise && ENABLE) begin
                    state_nxt = ST_WAIT_FREEZE;
                    cnt_nxt   = CONF_FREEZE_DLY;
                    start     = 1'b1;
                end
            end
            ST_WAIT_FREEZE: begin
                if (cnt == '0) begin
                    state_nxt = ST_READ;
                    cnt_nxt   = read_cnt;
                end
            end
            ST_READ: begin
                if (cnt == '0) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = bits_cnt;
                end
            end
            ST_SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = ST_STORE;
                end
            end
            ST_STORE: begin
                if (!FIFO_FULL) begin
                    hit_inc   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tok_s && limit_hit) begin
                    ovf_set   = 1'b1;
                    state_nxt = ST_UNFREEZE;
                    cnt_nxt   = CONF_STOP_DLY;
                end else if (tok_s && ENABLE) begin
                    state_nxt = ST_READ;
                    cnt_nxt   = read_cnt;
                end else begin
                    state_nxt = ST_UNFREEZE;
                    cnt_nxt   = CONF_STOP_DLY;
                end
            end
            ST_UNFREEZE: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so an async reset drops them immediately.
    always_comb begin
        RX_FREEZE   = 1'b0;
        RX_READ     = 1'b0;
        SHIFT_EN    = 1'b0;
        DATA_STROBE = 1'b0;
        BUSY        = (state != ST_IDLE);
        case (state)
            ST_WAIT_FREEZE: RX_FREEZE = (cnt == '0);
            ST_READ: begin
                RX_FREEZE = 1'b1;
                RX_READ   = 1'b1;
            end
            ST_SHIFT: begin
                RX_FREEZE = 1'b1;
                SHIFT_EN  = 1'b1;
            end
            ST_STORE: begin
                RX_FREEZE   = 1'b1;
                DATA_STROBE = !FIFO_FULL;
            end
            ST_GAP:      RX_FREEZE = 1'b1;
            ST_UNFREEZE: RX_FREEZE = (cnt != '0);
            default: ;
        endcase
    end

    always_ff @(posedge RX_CLK or negedge RX_RST_N) begin
        if (!RX_RST_N) begin
            cnt             <= '0;
            TOKEN_TIMESTAMP <= '0;
            HIT_CNT         <= '0;
            OVERFLOW        <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (start) begin
                TOKEN_TIMESTAMP <= TIMESTAMP;
                HIT_CNT         <= '0;
                OVERFLOW        <= 1'b0;
            end else begin
                if (hit_inc && (HIT_CNT != '1)) begin
                    HIT_CNT <= HIT_CNT + 1'b1;
                end
                if (ovf_set) begin
                    OVERFLOW <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mono_rx_readout_ctrl.sv
// Directed bench for mono_rx_readout_ctrl with a strobe scoreboard (expected cycle and HIT_CNT per strobe).
module tb_mono_rx_readout_ctrl;
    import mono_rx_pkg::*;

    localparam logic [63:0] TS_BASE = 64'hA5C3_0000_0000_0000;

    logic        RX_CLK = 1'b0;
    logic        RX_RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        RX_TOKEN = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [63:0] TIMESTAMP = '0;
    logic [7:0]  CONF_FREEZE_DLY = DEF_FREEZE_DLY;
    logic [3:0]  CONF_READ_WIDTH = DEF_READ_WIDTH;
    logic [5:0]  CONF_DATA_BITS = DEF_DATA_BITS;
    logic [7:0]  CONF_STOP_DLY = DEF_STOP_DLY;
    logic [15:0] CONF_MAX_HITS = '0;
    logic        RX_FREEZE, RX_READ, SHIFT_EN, DATA_STROBE, BUSY, OVERFLOW;
    logic [63:0] TOKEN_TIMESTAMP;
    logic [15:0] HIT_CNT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_read = 0;
    int n_shift = 0;
    int n_freeze = 0;

    typedef struct {
        int          cyc;
        logic [15:0] hit;
    } exp_t;
    exp_t sb[$];

    mono_rx_readout_ctrl #(.TS_WIDTH(64), .DATA_BITS_WIDTH(6), .CNT_WIDTH(16)) dut (
        .RX_CLK          (RX_CLK),
        .RX_RST_N        (RX_RST_N),
        .ENABLE          (ENABLE),
        .RX_TOKEN        (RX_TOKEN),
        .TIMESTAMP       (TIMESTAMP),
        .CONF_FREEZE_DLY (CONF_FREEZE_DLY),
        .CONF_READ_WIDTH (CONF_READ_WIDTH),
        .CONF_DATA_BITS  (CONF_DATA_BITS),
        .CONF_STOP_DLY   (CONF_STOP_DLY),
        .CONF_MAX_HITS   (CONF_MAX_HITS),
        .FIFO_FULL       (FIFO_FULL),
        .RX_FREEZE       (RX_FREEZE),
        .RX_READ         (RX_READ),
        .SHIFT_EN        (SHIFT_EN),
        .DATA_STROBE     (DATA_STROBE),
        .TOKEN_TIMESTAMP (TOKEN_TIMESTAMP),
        .BUSY            (BUSY),
        .HIT_CNT         (HIT_CNT),
        .OVERFLOW        (OVERFLOW)
    );

    always #5 RX_CLK = ~RX_CLK;
    always @(posedge RX_CLK) cyc <= cyc + 1;
    // Free-running timestamp: during cycle k it reads TS_BASE + k.
    always @(negedge RX_CLK) TIMESTAMP = TS_BASE + 64'(cyc);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge RX_CLK) begin
        if (RX_RST_N) begin
            if (RX_READ)   n_read++;
            if (SHIFT_EN)  n_shift++;
            if (RX_FREEZE) n_freeze++;
            if (DATA_STROBE) begin
                chk("strobe_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    chk("strobe_hit_cnt", 64'(HIT_CNT), 64'(e.hit));
                end
            end
        end
    end

    // Drive point: 1 time unit after the posedge that makes cyc == k.
    task automatic drv(input int k);
        do begin
            @(posedge RX_CLK);
            #1;
        end while (cyc < k);
    endtask

    // Sample point: the negedge inside cycle k.
    task automatic smp(input int k);
        do @(negedge RX_CLK); while (cyc < k);
    endtask

    task automatic launch(output int c, output int rd, output int sh, output int fz);
        drv(cyc + 8);
        c  = cyc;
        rd = n_read;
        sh = n_shift;
        fz = n_freeze;
        RX_TOKEN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, rd, sh, fz;
        ENABLE = 1'b1;

        // Reset state
        drv(2);
        chk("rst_freeze", 64'(RX_FREEZE), 0);
        chk("rst_read", 64'(RX_READ), 0);
        chk("rst_shift", 64'(SHIFT_EN), 0);
        chk("rst_strobe", 64'(DATA_STROBE), 0);
        chk("rst_busy", 64'(BUSY), 0);
        chk("rst_hit_cnt", 64'(HIT_CNT), 0);
        chk("rst_overflow", 64'(OVERFLOW), 0);
        chk("rst_token_ts", TOKEN_TIMESTAMP, 0);
        drv(3);
        RX_RST_N = 1'b1;

        // Single hit with default configuration
        launch(c0, rd, sh, fz);
        sb.push_back('{cyc: c0 + 34, hit: 16'd0});
        smp(c0 + 2);  chk("s1_busy_before_detect", 64'(BUSY), 0);
        smp(c0 + 3);  chk("s1_busy_after_detect", 64'(BUSY), 1);
        smp(c0 + 4);  chk("s1_freeze_early", 64'(RX_FREEZE), 0);
        smp(c0 + 5);  chk("s1_freeze_on", 64'(RX_FREEZE), 1);
                      chk("s1_read_not_yet", 64'(RX_READ), 0);
        smp(c0 + 6);  chk("s1_read_on", 64'(RX_READ), 1);
        drv(c0 + 10); RX_TOKEN = 1'b0;
        smp(c0 + 36); chk("s1_hit_cnt", 64'(HIT_CNT), 1);
                      chk("s1_token_ts", TOKEN_TIMESTAMP, TS_BASE + 64'(c0 + 2));
        smp(c0 + 39); chk("s1_freeze_held", 64'(RX_FREEZE), 1);
        smp(c0 + 40); chk("s1_freeze_off", 64'(RX_FREEZE), 0);
                      chk("s1_busy_unfreeze", 64'(BUSY), 1);
        drv(c0 + 41); chk("s1_idle", 64'(BUSY), 0);
        chk("s1_read_cycles", 64'(n_read - rd), 2);
        chk("s1_shift_cycles", 64'(n_shift - sh), 26);
        chk("s1_freeze_cycles", 64'(n_freeze - fz), 35);

        // Three hits while the token stays high
        launch(c0, rd, sh, fz);
        sb.push_back('{cyc: c0 + 34, hit: 16'd0});
        sb.push_back('{cyc: c0 + 64, hit: 16'd1});
        sb.push_back('{cyc: c0 + 94, hit: 16'd2});
        smp(c0 + 66); chk("s2_reread", 64'(RX_READ), 1);
        drv(c0 + 80); RX_TOKEN = 1'b0;
        drv(c0 + 101);
        chk("s2_idle", 64'(BUSY), 0);
        chk("s2_hit_cnt", 64'(HIT_CNT), 3);
        chk("s2_read_cycles", 64'(n_read - rd), 6);
        chk("s2_shift_cycles", 64'(n_shift - sh), 78);
        chk("s2_freeze_cycles", 64'(n_freeze - fz), 95);

        // FIFO_FULL stall at STORE plus an ignored token edge while busy
        launch(c0, rd, sh, fz);
        sb.push_back('{cyc: c0 + 44, hit: 16'd0});
        drv(c0 + 10); RX_TOKEN = 1'b0;
        drv(c0 + 20); RX_TOKEN = 1'b1;
        drv(c0 + 25); RX_TOKEN = 1'b0;
        drv(c0 + 34); FIFO_FULL = 1'b1;
        smp(c0 + 40); chk("s3_no_strobe_full", 64'(DATA_STROBE), 0);
                      chk("s3_busy_full", 64'(BUSY), 1);
        drv(c0 + 44); FIFO_FULL = 1'b0;
        drv(c0 + 51);
        chk("s3_idle", 64'(BUSY), 0);
        chk("s3_hit_cnt", 64'(HIT_CNT), 1);
        chk("s3_token_ts", TOKEN_TIMESTAMP, TS_BASE + 64'(c0 + 2));
        chk("s3_read_cycles", 64'(n_read - rd), 2);
        chk("s3_freeze_cycles", 64'(n_freeze - fz), 45);

        // Max-hit limit with the token stuck high
        CONF_MAX_HITS = 16'd2;
        launch(c0, rd, sh, fz);
        sb.push_back('{cyc: c0 + 34, hit: 16'd0});
        sb.push_back('{cyc: c0 + 64, hit: 16'd1});
        smp(c0 + 66); chk("s4_overflow_set", 64'(OVERFLOW), 1);
                      chk("s4_freeze_held", 64'(RX_FREEZE), 1);
        drv(c0 + 71);
        chk("s4_idle", 64'(BUSY), 0);
        chk("s4_freeze_released", 64'(RX_FREEZE), 0);
        chk("s4_hit_cnt", 64'(HIT_CNT), 2);
        chk("s4_overflow_sticky", 64'(OVERFLOW), 1);
        drv(c0 + 80);
        chk("s4_no_restart_level", 64'(BUSY), 0);
        RX_TOKEN = 1'b0;
        launch(c1, rd, sh, fz);
        sb.push_back('{cyc: c1 + 34, hit: 16'd0});
        smp(c1 + 3);  chk("s4_overflow_cleared", 64'(OVERFLOW), 0);
                      chk("s4_hit_cnt_cleared", 64'(HIT_CNT), 0);
        drv(c1 + 10); RX_TOKEN = 1'b0;
        drv(c1 + 41); chk("s4_idle2", 64'(BUSY), 0);
                      chk("s4_hit_cnt2", 64'(HIT_CNT), 1);

        // ENABLE dropped during SHIFT, then a token edge with ENABLE low
        CONF_MAX_HITS = '0;
        launch(c0, rd, sh, fz);
        sb.push_back('{cyc: c0 + 34, hit: 16'd0});
        drv(c0 + 20); ENABLE = 1'b0;
        smp(c0 + 35); chk("s5_freeze_gap", 64'(RX_FREEZE), 1);
        drv(c0 + 41);
        chk("s5_idle", 64'(BUSY), 0);
        chk("s5_hit_cnt", 64'(HIT_CNT), 1);
        chk("s5_read_cycles", 64'(n_read - rd), 2);
        drv(c0 + 45); RX_TOKEN = 1'b0;
        drv(c0 + 55); RX_TOKEN = 1'b1;
        smp(c0 + 62); chk("s5_disabled_busy", 64'(BUSY), 0);
                      chk("s5_token_ts_kept", TOKEN_TIMESTAMP, TS_BASE + 64'(c0 + 2));
        drv(c0 + 63); RX_TOKEN = 1'b0; ENABLE = 1'b1;

        // Async reset during SHIFT, then restart with DLY=0, RW=0, BITS=0
        launch(c0, rd, sh, fz);
        drv(c0 + 20);
        chk("s6_shift_before_rst", 64'(SHIFT_EN), 1);
        RX_RST_N = 1'b0;
        #1;
        chk("s6_rst_freeze", 64'(RX_FREEZE), 0);
        chk("s6_rst_shift", 64'(SHIFT_EN), 0);
        chk("s6_rst_read", 64'(RX_READ), 0);
        chk("s6_rst_busy", 64'(BUSY), 0);
        RX_TOKEN = 1'b0;
        drv(c0 + 22);
        RX_RST_N = 1'b1;
        CONF_FREEZE_DLY = 8'd0;
        CONF_READ_WIDTH = 4'd0;
        CONF_DATA_BITS  = 6'd0;
        launch(c1, rd, sh, fz);
        sb.push_back('{cyc: c1 + 6, hit: 16'd0});
        smp(c1 + 2);  chk("s6_freeze_early", 64'(RX_FREEZE), 0);
        smp(c1 + 3);  chk("s6_freeze_dly0", 64'(RX_FREEZE), 1);
        drv(c1 + 4);  RX_TOKEN = 1'b0;
        drv(c1 + 13);
        chk("s6_idle", 64'(BUSY), 0);
        chk("s6_read_cycles", 64'(n_read - rd), 1);
        chk("s6_shift_cycles", 64'(n_shift - sh), 1);
        chk("s6_freeze_cycles", 64'(n_freeze - fz), 9);
        chk("s6_hit_cnt", 64'(HIT_CNT), 1);
        chk("s6_token_ts", TOKEN_TIMESTAMP, TS_BASE + 64'(c1 + 2));

        drv(cyc + 5);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
